// File: rtl/pipe_share_arb.sv
// pipe_share_arb: shares one fixed-latency pipe_mem delay line between two
// requesters (A and B). It grants at most one word per cycle by round-robin,
// tags each word in flight, and steers the delayed pipe output back to the
// requester that owns it. A stop/drain/idle sequence lets upstream logic
// quiesce the shared line.
//
// Optional feature macro: PIPE_ARB_STATS_EN
//   When defined, adds saturating per-requester transfer counters
//   a_count / b_count of width CW.
module pipe_share_arb #(
  parameter int H  = 3,   // pipe_mem latency in cycles, H >= 1
  parameter int W  = 32,  // data width
  parameter int CW = 16   // statistics counter width
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [W-1:0]  a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [W-1:0]  b_data,
  output logic          b_ready,
  output logic [W-1:0]  pipe_in,
  input  logic [W-1:0]  pipe_out,
  output logic          a_out_valid,
  output logic [W-1:0]  a_out,
  output logic          b_out_valid,
  output logic [W-1:0]  b_out,
  input  logic          stop,
  output logic          idle
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
`endif
);

  localparam int IW = $clog2(H + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  // Source identifier carried alongside each word in flight.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_t         state, state_next;
  logic           last_grant;
  logic [H-1:0]   tag_v;
  logic [H-1:0]   tag_src;
  logic [IW-1:0]  inflight, inflight_next;

  logic           run_ok;
  logic           grant_a, grant_b;
  logic           xfer;
  logic           grant_src;
  logic           exit_v, exit_src;
  logic           drained;

  // The tag leaving stage H-1 lines up with the word on pipe_out.
  assign exit_v   = tag_v[H-1];
  assign exit_src = tag_src[H-1];

  // Round-robin grant: a tie goes to whichever requester was not served last.
  always_comb begin
    run_ok    = (state == ST_RUN) && !stop;
    grant_a   = run_ok && a_valid && (!b_valid || (last_grant == SRC_B));
    grant_b   = run_ok && b_valid && !grant_a;
    xfer      = grant_a || grant_b;
    grant_src = grant_b ? SRC_B : SRC_A;
    a_ready   = grant_a;
    b_ready   = grant_b;
    pipe_in   = grant_a ? a_data : (grant_b ? b_data : '0);
  end

  // Steer the delayed word to its owner; ports read 0 when not owned.
  always_comb begin
    a_out_valid = exit_v && (exit_src == SRC_A);
    b_out_valid = exit_v && (exit_src == SRC_B);
    a_out       = a_out_valid ? pipe_out : '0;
    b_out       = b_out_valid ? pipe_out : '0;
  end

  // Occupancy after this cycle: one in per transfer, one out per exiting tag.
  always_comb begin
    inflight_next = inflight;
    case ({xfer, exit_v})
      2'b10:   inflight_next = inflight + IW'(1);
      2'b01:   inflight_next = inflight - IW'(1);
      default: inflight_next = inflight;
    endcase
    // Grants are already blocked while stopping, so this means the line
    // holds nothing once the current cycle ends.
    drained = (inflight_next == '0);
  end

  // Stop/drain/idle sequencing; an already-empty line skips straight to idle.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (stop)    state_next = drained ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (drained) state_next = ST_IDLE;
      ST_IDLE:  if (!stop)   state_next = ST_RUN;
      default:               state_next = ST_RUN;
    endcase
  end

  // Control state, round-robin pointer, occupancy and registered idle flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      last_grant <= SRC_B;
      inflight   <= '0;
      idle       <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      idle     <= (state_next == ST_IDLE);
      if (xfer) last_grant <= grant_src;
    end
  end

  // Tag line shifts every cycle in step with the external pipe_mem.
  // NOTE: only the valid bits are reset; the source bits are meaningless
  // while their valid bit is low, so they skip the reset path.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= xfer;
      for (int i = 1; i < H; i++) tag_v[i] <= tag_v[i-1];
    end
    tag_src[0] <= grant_src;
    for (int i = 1; i < H; i++) tag_src[i] <= tag_src[i-1];
  end

`ifdef PIPE_ARB_STATS_EN
  // Per-requester transfer counters that hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (grant_a && (a_count != '1)) a_count <= a_count + CW'(1);
      if (grant_b && (b_count != '1)) b_count <= b_count + CW'(1);
    end
  end
`endif

endmodule
